// File: rtl/cordic_pkg.sv
// Shared constants, arctangent table and FSM state type for the iterative CORDIC cos/sin engine.
// All angle and magnitude constants are stored in Q2.22.
package cordic_pkg;

    localparam int WIDTH  = 24;
    localparam int FRAC   = 22;
    localparam int ATAN_N = 22;

    localparam logic [WIDTH-1:0] K_Q22   = 24'h26DD3B;
    localparam logic [WIDTH-1:0] ONE_Q22 = 24'h400000;

    // atan(2^-i) * 2^22, rounded to nearest
    localparam logic [WIDTH-1:0] ATAN [ATAN_N] = '{
        24'h3243F6, 24'h1DAC67, 24'h0FADBB, 24'h07F56F,
        24'h03FEAB, 24'h01FFD5, 24'h00FFFB, 24'h007FFF,
        24'h004000, 24'h002000, 24'h001000, 24'h000800,
        24'h000400, 24'h000200, 24'h000100, 24'h000080,
        24'h000040, 24'h000020, 24'h000010, 24'h000008,
        24'h000004, 24'h000002
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/cordic_step.sv
// One rotation-mode CORDIC micro-rotation, purely combinational.
// Direction follows the sign of the residual angle z.
module cordic_step
    import cordic_pkg::*;
#(
    parameter int IW     = WIDTH + 2,
    parameter int FRAC_W = FRAC,
    parameter int CW     = 5
) (
    input  logic signed [IW-1:0] x_i,
    input  logic signed [IW-1:0] y_i,
    input  logic signed [IW-1:0] z_i,
    input  logic        [CW-1:0] iter_i,
    output logic signed [IW-1:0] x_o,
    output logic signed [IW-1:0] y_o,
    output logic signed [IW-1:0] z_o
);

    logic signed [IW-1:0] x_sh;
    logic signed [IW-1:0] y_sh;
    logic signed [IW-1:0] atan_v;
    logic                 rot_pos;

    // NOTE: every output of a combinational block gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        rot_pos = ~z_i[IW-1];
        x_sh    = x_i >>> iter_i;
        y_sh    = y_i >>> iter_i;
        // Table is Q22; rescale if the datapath carries fewer fraction bits
        atan_v  = IW'(ATAN[iter_i]) >>> (FRAC - FRAC_W);
        if (rot_pos) begin
            x_o = x_i - y_sh;
            y_o = y_i + x_sh;
            z_o = z_i - atan_v;
        end else begin
            x_o = x_i + y_sh;
            y_o = y_i - x_sh;
            z_o = z_i + atan_v;
        end
    end

endmodule

// File: rtl/cordic_cos_iter.sv
// Iterative CORDIC cos/sin engine: IDLE -> RUN (ITERATIONS cycles) -> DONE, gated by clk_en.
// Results register on leaving DONE and hold until the next operation completes.
module cordic_cos_iter #(
    parameter int WIDTH      = 24,
    parameter int FRAC       = 22,
    parameter int ITERATIONS = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clk_en,
    input  logic             start,
    input  logic [WIDTH-1:0] angle_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] cos_out,
    output logic [WIDTH-1:0] sin_out
);

    import cordic_pkg::*;

    localparam int IW = WIDTH + 2;
    localparam int CW = 5;
    localparam logic [CW-1:0] LAST_ITER = CW'(ITERATIONS - 1);
    localparam logic signed [IW-1:0] K_INIT = IW'(K_Q22) >>> (cordic_pkg::FRAC - FRAC);

    state_e               state_q, state_d;
    logic [CW-1:0]        iter_q, iter_d;
    logic signed [IW-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic signed [IW-1:0] x_step, y_step, z_step;
    logic [WIDTH-1:0]     cos_q, cos_d, sin_q, sin_d;
    logic                 done_q, done_d;

    cordic_step #(
        .IW     (IW),
        .FRAC_W (FRAC),
        .CW     (CW)
    ) u_step (
        .x_i    (x_q),
        .y_i    (y_q),
        .z_i    (z_q),
        .iter_i (iter_q),
        .x_o    (x_step),
        .y_o    (y_step),
        .z_o    (z_step)
    );

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        cos_d   = cos_q;
        sin_d   = sin_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // The cycle showing done still counts as the tail of the previous operation
                if (start && !done_q) begin
                    x_d     = K_INIT;
                    y_d     = '0;
                    z_d     = {{(IW-WIDTH){angle_in[WIDTH-1]}}, angle_in};
                    iter_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                x_d    = x_step;
                y_d    = y_step;
                z_d    = z_step;
                iter_d = iter_q + 1'b1;
                if (iter_q == LAST_ITER) state_d = DONE;
            end
            DONE: begin
                cos_d   = x_q[WIDTH-1:0];
                sin_d   = y_q[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            iter_q  <= '0;
            cos_q   <= '0;
            sin_q   <= '0;
            done_q  <= 1'b0;
        end else if (clk_en) begin
            state_q <= state_d;
            iter_q  <= iter_d;
            cos_q   <= cos_d;
            sin_q   <= sin_d;
            done_q  <= done_d;
        end
    end

    // NOTE: the x/y/z working registers are always loaded before use, so they carry no reset.
    always_ff @(posedge clk) begin
        if (clk_en) begin
            x_q <= x_d;
            y_q <= y_d;
            z_q <= z_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = done_q;
    assign cos_out = cos_q;
    assign sin_out = sin_q;

endmodule

// File: tb/tb_cordic_cos_iter.sv
// Directed bench for cordic_cos_iter: latency, busy/done profile, stalls, ignored starts and reset abort.
// Expected cos/sin values are hand-computed references with a 256 LSB tolerance.
module tb_cordic_cos_iter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clk_en;
    logic        start;
    logic [23:0] angle_in;
    logic        busy;
    logic        done;
    logic [23:0] cos_out;
    logic [23:0] sin_out;

    int     n_vec  = 0;
    int     n_bad  = 0;
    longint prev_cos = 0;
    longint prev_sin = 0;

    always #5 clk = ~clk;

    cordic_cos_iter dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .clk_en   (clk_en),
        .start    (start),
        .angle_in (angle_in),
        .busy     (busy),
        .done     (done),
        .cos_out  (cos_out),
        .sin_out  (sin_out)
    );

    task automatic check(input string tag, input longint got, input longint exp, input longint tol = 0);
        n_vec++;
        if (got > exp + tol || got < exp - tol) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint sv(input logic [23:0] v);
        return longint'($signed(v));
    endfunction

    task automatic check_out(input string tag, input longint c, input longint s);
        check({tag, ".cos"}, sv(cos_out), c, 256);
        check({tag, ".sin"}, sv(sin_out), s, 256);
    endtask

    // One operation; edge 0 samples start, done expected after edge 17 + stall_len.
    task automatic run_op(input string tag, input logic [23:0] angle, input longint ec, input longint es,
                          input int stall_at, input int stall_len, input int poke_at);
        int exp_edges;
        int n;
        exp_edges = 17 + stall_len;
        n = 0;
        angle_in = angle;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        check({tag, ".busy_on"}, busy, 1);
        while (n < exp_edges) begin
            if (n == poke_at) begin
                angle_in = 24'hC00000;
                start    = 1'b1;
            end
            if (n == stall_at) clk_en = 1'b0;
            if (n == stall_at + stall_len) clk_en = 1'b1;
            tick();
            n++;
            start    = 1'b0;
            angle_in = angle;
            check({tag, ".busy"}, busy, longint'(n < exp_edges - 1));
            check({tag, ".done"}, done, longint'(n == exp_edges));
            if (n < exp_edges) begin
                check({tag, ".hold_cos"}, sv(cos_out), prev_cos, 256);
                check({tag, ".hold_sin"}, sv(sin_out), prev_sin, 256);
            end
        end
        check_out(tag, ec, es);
        tick();
        check({tag, ".done_pulse"}, done, 0);
        prev_cos = ec;
        prev_sin = es;
    endtask

    initial begin
        int done_cnt;
        reset_n  = 1'b0;
        clk_en   = 1'b1;
        start    = 1'b0;
        angle_in = '0;
        repeat (2) tick();
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.cos", sv(cos_out), 0);
        check("rst.sin", sv(sin_out), 0);
        reset_n = 1'b1;
        tick();

        run_op("zero",  24'h000000, 4194304, 0,        -1, 0, -1);
        run_op("p077",  24'h31472B, 3011160, 2919818,  -1, 0, -1);
        run_op("m007",  24'hFB8535, 4184032, -293361,  -1, 0, -1);
        run_op("m100",  24'hC00000, 2266191, -3529377, -1, 0, -1);

        // start held for 20 edges: accepted at edge 0, ignored while done shows, re-accepted at edge 19
        done_cnt = 0;
        angle_in = 24'hC00000;
        start    = 1'b1;
        for (int e = 0; e < 38; e++) begin
            tick();
            if (e == 19) start = 1'b0;
            if (done) done_cnt++;
            check("held.busy", busy, longint'(e <= 15 || (e >= 19 && e <= 34)));
            check("held.done", done, longint'(e == 17 || e == 36));
            if (e == 17 || e == 36) check_out("held", 2266191, -3529377);
        end
        check("held.done_cnt", done_cnt, 2);
        tick();

        run_op("stall", 24'h31472B, 3011160, 2919818, 8, 7, -1);
        run_op("poke",  24'h31472B, 3011160, 2919818, -1, 0, 3);

        // Abort at iteration 5 with clk_en low: reset still wins and no done follows
        angle_in = 24'h31472B;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        repeat (5) tick();
        reset_n = 1'b0;
        clk_en  = 1'b0;
        tick();
        reset_n = 1'b1;
        clk_en  = 1'b1;
        check("abort.busy", busy, 0);
        check("abort.done", done, 0);
        check("abort.cos", sv(cos_out), 0);
        check("abort.sin", sv(sin_out), 0);
        done_cnt = 0;
        repeat (25) begin
            tick();
            if (done || busy) done_cnt++;
        end
        check("abort.quiet", done_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/cordic_cos_iter.md
Name: cordic_cos_iter

Overview:
- Iterative rotation-mode CORDIC engine. Sits directly downstream of float_to_fixed and consumes its 24-bit fixed-point angle.
- Produces cos and sin of the angle in the same fixed-point format after a fixed number of clocked iterations.
- Uses a start/done handshake with a clock enable, so it can be wrapped as a multi-cycle custom instruction.

Parameters:
- WIDTH, 24, datapath width; signed two's-complement Q2.22 (sign, 1 integer bit, 22 fraction bits).
- FRAC, 22, number of fraction bits.
- ITERATIONS, 16, number of CORDIC micro-rotations (legal range 8..22).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset_n  input  1  synchronous active-low reset.
- clk_en  input  1  when low, all registers hold (state, counter, datapath, outputs).
- start  input  1  request; sampled only in IDLE with clk_en high.
- angle_in  input  WIDTH  angle in radians, Q2.22; valid range [-1.0, +1.0].
- busy  output  1  high while an operation is in progress (RUN state).
- done  output  1  single-cycle pulse when results become valid.
- cos_out  output  WIDTH  cos(angle_in), Q2.22.
- sin_out  output  WIDTH  sin(angle_in), Q2.22.

Behaviour:
- Reset: on a clk edge with reset_n low, regardless of clk_en:
  - state=IDLE; busy=0; done=0; cos_out=0; sin_out=0; iteration counter=0.
  - Any operation in flight is discarded and no done is issued.
- All transitions below apply only on edges with reset_n high and clk_en high.
- IDLE:
  - If start=1: load x=K=0x26DD3B (0.6072529 in Q2.22), y=0, z=angle_in; set i=0; go to RUN; busy=1 from the next cycle.
  - If start=0: remain in IDLE.
- RUN, one micro-rotation per cycle:
  - d = +1 if z>=0, else -1.
  - x <= x - d*(y>>>i); y <= y + d*(x>>>i); z <= z - d*ATAN[i]. The shifts are arithmetic. x, y and z update simultaneously from their pre-edge values.
  - i <= i+1.
  - When i==ITERATIONS-1: go to DONE.
- DONE, exactly 1 cycle:
  - cos_out<=x; sin_out<=y; done=1; busy=0; then go to IDLE.
- Latency: start sampled on edge 0 → done high during the cycle after edge ITERATIONS+1. Example: default 16 → 17 edges from start to done.
- Outputs hold their last result until the next DONE. They are never modified during RUN.
- start while busy or in DONE: ignored, no queueing. start high for several cycles in IDLE: accepted once only, because the state leaves IDLE immediately.
- Back-to-back: start asserted in the cycle done is high is ignored. The earliest accepted start is in the following IDLE cycle.
- clk_en low mid-RUN: freezes everything. Operation resumes with an identical result; done is delayed by the stall length. A done pulse stretched by clk_en low stays high until the next enabled edge.
- Arithmetic:
  - Internal x/y/z are WIDTH+2 bits to absorb CORDIC gain and overflow.
  - Outputs are truncated to WIDTH. Magnitude is ≤1.0, so this is a lossless sign-correct slice.
- Inputs outside [-1,1] yield unspecified values, but the FSM timing is unchanged.
- Accuracy: |error| ≤ 256 LSB (2^-14) for ITERATIONS=16.

Decomposition:
- cordic_pkg holds:
  - Q2.22 constants: WIDTH, FRAC, K_Q22=0x26DD3B, ONE_Q22=0x400000.
  - ATAN[0..21] table as a constant array, atan(2^-i)*2^22 rounded; ATAN[0]=0x3243F6, ATAN[1]=0x1DAC67, ATAN[2]=0x0FADBB.
  - State enum {IDLE, RUN, DONE}.
- One natural sub-module: cordic_step. It is combinational and computes one micro-rotation from inputs x, y, z, i. The top holds the FSM, counter and registers, and instantiates cordic_step once.

Test Plan:
- Reset mid-RUN: start with angle_in=0x31472B, drop reset_n for 1 cycle at iteration 5 → busy=0, done never pulses, cos_out=sin_out=0.
- angle_in=0 (0x000000), start → done on edge 17; cos_out=4194304±256 (0x400000), sin_out=0±256.
- angle_in=0x31472B (0.77) → cos_out≈3011160±256, sin_out≈2919818±256. Then angle_in=0xFB8535 (-0.07) → cos_out≈4184032±256, sin_out≈-293361±256.
- angle_in=0xC00000 (-1.0) → cos_out≈2266191±256, sin_out≈-3529377±256. Repeat with start held high for 20 cycles → exactly one done per accepted start; a second start is accepted only after done.
- clk_en low for 7 cycles at iteration 8 of the 0.77 case → identical results; done arrives on edge 24; outputs unchanged during the stall.
- start pulsed while busy at iteration 3 with a different angle_in → ignored; result matches the original angle; busy profile unchanged.
